display_scan_decoder: RTL and testbench
=======================================

// Module: display_scan_decoder
// PURPOSE
//  Receiving end of the multiplexed 7-segment scan bus driven by the clock block.
//  Samples segment_data/digit_select every clk_1ms, decodes each digit back to BCD,
//  and reassembles a full 5-digit frame (M1 M10 colon H1 H10) into binary hours/minutes.
//  Flags sequence, pattern and range errors. Used as a display monitor/self-check in the top level.
// PARAMETERS
//  BLINK_TIMEOUT_FRAMES  400  frames with no colon toggle before blink_err (2 s at 5 ms/frame)
//  MAX_HOURS             23   largest legal decoded hour value
// PORTS
//  clk_1ms       in   1  scan clock; all state updates on posedge
//  reset_n       in   1  asynchronous, active-low reset
//  segment_data  in   7  active-high segments, bit6=a .. bit0=g
//  digit_select  in   3  digit index: 0=min ones, 1=min tens, 2=colon, 3=hr ones, 4=hr tens
//  hours         out  5  last committed hours, binary
//  minutes       out  6  last committed minutes, binary
//  colon         out  1  last committed colon state
//  frame_valid   out  1  1-cycle pulse when a clean frame commits
//  locked        out  1  high while in SCAN state
//  seq_err       out  1  1-cycle pulse: digit_select out of order or >4
//  seg_err       out  1  1-cycle pulse: frame ended containing an undecodable pattern
//  range_err     out  1  1-cycle pulse: frame decoded but minutes>59 or hours>MAX_HOURS
//  blink_err     out  1  level; only with COLON_BLINK_CHECK_EN, else tied 0
// BEHAVIOUR
//  - Reset: all outputs 0, state HUNT, shadow digit regs 0, bad-frame flag 0.
//  - Inputs sampled on every posedge clk_1ms; one digit per cycle.
//  - Digit decode (pos 0,1,3,4): 1111110=0 0110000=1 1101101=2 1111001=3 0110011=4
//    1011011=5 1011111=6 1110000=7 1111111=8 1110011=9; anything else = invalid.
//  - Colon decode (pos 2): 1111111 -> 1, 0000000 -> 0, anything else = invalid.
//  - FSM HUNT: wait for digit_select==0; capture digit 0, clear bad flag, go SCAN, expect=1.
//  - FSM SCAN: digit_select must equal expect; capture, expect++. Invalid pattern sets bad flag.
//    On digit 4: if bad -> seg_err; else if tens/ones out of range (min>59, hr>MAX_HOURS)
//    -> range_err; else commit hours=H10*10+H1, minutes=M10*10+M1, colon, pulse frame_valid.
//    Then expect=0 and stay in SCAN.
//  - Out-of-order index in SCAN: seq_err pulse; if observed index==0 treat as new frame start
//    (capture, expect=1, stay SCAN), else go HUNT. Index 5..7 always -> seq_err, HUNT.
//  - All status pulses and committed outputs are registered: asserted the cycle after digit 4
//    is sampled (1-cycle latency); outputs hold until next commit.
//  - Errors never modify hours/minutes/colon. Reset mid-frame discards the partial frame.
//  - Arithmetic: tens*10 computed at 7 bits, truncated to port width only after range check.
// CONFIGURATION
//  COLON_BLINK_CHECK_EN defined: frame counter (clog2(BLINK_TIMEOUT_FRAMES+1) bits) counts
//    committed frames since last colon change; reaching BLINK_TIMEOUT_FRAMES sets blink_err,
//    which clears on the next committed colon change. Counter saturates, reset clears both.
//  Not defined: no counter, blink_err driven constant 0.
// STRUCTURE
//  Package display_scan_pkg: segment pattern constants (SEG_0..SEG_9, SEG_ALL_ON, SEG_ALL_OFF),
//    digit-position enum (POS_M1, POS_M10, POS_COLON, POS_H1, POS_H10), FSM state enum.
//  Sub-module seg7_to_bcd: combinational pattern -> {valid, bcd[3:0]} decoder, one instance.
// TESTING
//  1. Drive scan 0..4 for 12:34, colon on -> frame_valid 1 cycle after pos4, hours=12 minutes=34 colon=1.
//  2. Start mid-frame at pos 3, then full frame 23:59 -> no commit until first pos0; then 23/59.
//  3. Sequence 0,1,3 -> seq_err at pos3, locked=0; next frame 0..4 commits normally.
//  4. Pos1 pattern 0000001 -> seg_err after pos4, outputs keep previous 12:34.
//  5. Frame encoding 25:61 -> range_err, no frame_valid, outputs unchanged.
//  6. COLON_BLINK_CHECK_EN, colon held 1 for 400 frames -> blink_err=1; toggle -> clears.

Source files
------------

// File: rtl/display_scan_pkg.sv
// Shared constants and types for the scan-bus display decoder: segment patterns, scan positions, FSM states.
// Pure definitions, no latency; no flow control.
package display_scan_pkg;

    localparam logic [6:0] SEG_0       = 7'b1111110;
    localparam logic [6:0] SEG_1       = 7'b0110000;
    localparam logic [6:0] SEG_2       = 7'b1101101;
    localparam logic [6:0] SEG_3       = 7'b1111001;
    localparam logic [6:0] SEG_4       = 7'b0110011;
    localparam logic [6:0] SEG_5       = 7'b1011011;
    localparam logic [6:0] SEG_6       = 7'b1011111;
    localparam logic [6:0] SEG_7       = 7'b1110000;
    localparam logic [6:0] SEG_8       = 7'b1111111;
    localparam logic [6:0] SEG_9       = 7'b1110011;
    localparam logic [6:0] SEG_ALL_ON  = 7'b1111111;
    localparam logic [6:0] SEG_ALL_OFF = 7'b0000000;

    localparam int BLINK_TIMEOUT_FRAMES_DEF = 400;
    localparam int MAX_HOURS_DEF            = 23;

    typedef enum logic [2:0] {
        POS_M1    = 3'd0,
        POS_M10   = 3'd1,
        POS_COLON = 3'd2,
        POS_H1    = 3'd3,
        POS_H10   = 3'd4
    } digit_pos_e;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [3:0] h10;
        logic [3:0] h1;
        logic [3:0] m10;
        logic [3:0] m1;
        logic       colon;
    } frame_t;

    // Kept at 7 bits so an out-of-range value like 99 survives until the range check.
    function automatic logic [6:0] tens_ones(input logic [3:0] tens, input logic [3:0] ones);
        return ({3'd0, tens} * 7'd10) + {3'd0, ones};
    endfunction

endpackage

// File: rtl/display_scan_decoder_seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder with a validity flag.
// Zero latency; no flow control.
import display_scan_pkg::*;

module seg7_to_bcd (
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] bcd
);

    always_comb begin
        valid = 1'b1;
        bcd   = 4'd0;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/display_scan_decoder.sv
// Reassembles the 5-position 7-segment scan bus into hours/minutes/colon, flags sequence/pattern/range faults.
// 1-cycle latency from digit 4 to commit/status; no backpressure (free-running scan). Option: COLON_BLINK_CHECK_EN.
import display_scan_pkg::*;

module display_scan_decoder #(
    parameter int BLINK_TIMEOUT_FRAMES = BLINK_TIMEOUT_FRAMES_DEF,
    parameter int MAX_HOURS            = MAX_HOURS_DEF
) (
    input  logic       clk_1ms,
    input  logic       reset_n,
    input  logic [6:0] segment_data,
    input  logic [2:0] digit_select,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic       colon,
    output logic       frame_valid,
    output logic       locked,
    output logic       seq_err,
    output logic       seg_err,
    output logic       range_err,
    output logic       blink_err
);

    scan_state_e state_q, state_d;
    logic [2:0]  expect_q, expect_d;
    frame_t      shadow_q, shadow_d;
    logic        bad_q, bad_d;

    logic [4:0]  hours_d;
    logic [5:0]  minutes_d;
    logic        colon_d;
    logic        frame_valid_d, seq_err_d, seg_err_d, range_err_d;
    logic        commit;

    logic        dig_vld;
    logic [3:0]  dig_bcd;
    logic        colon_vld, colon_on, pat_vld;
    logic        start, take;
    logic [6:0]  mins7, hrs7;

    seg7_to_bcd u_seg7_to_bcd (
        .seg   (segment_data),
        .valid (dig_vld),
        .bcd   (dig_bcd)
    );

    // The colon position has its own two-pattern alphabet; SEG_8 there means "on".
    assign colon_on  = (segment_data == SEG_ALL_ON);
    assign colon_vld = colon_on || (segment_data == SEG_ALL_OFF);
    assign pat_vld   = (digit_select == POS_COLON) ? colon_vld : dig_vld;
    assign locked    = (state_q == ST_SCAN);

    always_comb begin
        state_d       = state_q;
        expect_d      = expect_q;
        shadow_d      = shadow_q;
        bad_d         = bad_q;
        hours_d       = hours;
        minutes_d     = minutes;
        colon_d       = colon;
        frame_valid_d = 1'b0;
        seq_err_d     = 1'b0;
        seg_err_d     = 1'b0;
        range_err_d   = 1'b0;
        commit        = 1'b0;
        start         = 1'b0;
        take          = 1'b0;
        mins7         = 7'd0;
        hrs7          = 7'd0;

        if (digit_select > POS_H10) begin
            seq_err_d = 1'b1;
            state_d   = ST_HUNT;
        end else if (state_q == ST_HUNT) begin
            start = (digit_select == POS_M1);
        end else if (digit_select == expect_q) begin
            take = 1'b1;
        end else begin
            seq_err_d = 1'b1;
            if (digit_select == POS_M1) begin
                start = 1'b1;
            end else begin
                state_d = ST_HUNT;
            end
        end

        if (start || take) begin
            state_d  = ST_SCAN;
            expect_d = digit_select + 3'd1;
            // Any position-0 capture opens a fresh frame, so the bad flag restarts there.
            bad_d    = (digit_select == POS_M1) ? !pat_vld : (bad_q || !pat_vld);
            case (digit_select)
                POS_M1:    shadow_d.m1    = dig_bcd;
                POS_M10:   shadow_d.m10   = dig_bcd;
                POS_COLON: shadow_d.colon = colon_on;
                POS_H1:    shadow_d.h1    = dig_bcd;
                POS_H10:   shadow_d.h10   = dig_bcd;
                default:   ;
            endcase
        end

        if (take && (digit_select == POS_H10)) begin
            expect_d = 3'd0;
            mins7    = tens_ones(shadow_d.m10, shadow_d.m1);
            hrs7     = tens_ones(shadow_d.h10, shadow_d.h1);
            if (bad_d) begin
                seg_err_d = 1'b1;
            end else if ((mins7 > 7'd59) || (hrs7 > 7'(MAX_HOURS))) begin
                range_err_d = 1'b1;
            end else begin
                commit        = 1'b1;
                frame_valid_d = 1'b1;
                hours_d       = hrs7[4:0];
                minutes_d     = mins7[5:0];
                colon_d       = shadow_d.colon;
            end
        end
    end

    always_ff @(posedge clk_1ms or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HUNT;
            expect_q    <= 3'd0;
            shadow_q    <= '0;
            bad_q       <= 1'b0;
            hours       <= 5'd0;
            minutes     <= 6'd0;
            colon       <= 1'b0;
            frame_valid <= 1'b0;
            seq_err     <= 1'b0;
            seg_err     <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            expect_q    <= expect_d;
            shadow_q    <= shadow_d;
            bad_q       <= bad_d;
            hours       <= hours_d;
            minutes     <= minutes_d;
            colon       <= colon_d;
            frame_valid <= frame_valid_d;
            seq_err     <= seq_err_d;
            seg_err     <= seg_err_d;
            range_err   <= range_err_d;
        end
    end

`ifdef COLON_BLINK_CHECK_EN
    localparam int CNT_W = $clog2(BLINK_TIMEOUT_FRAMES + 1);

    logic [CNT_W-1:0] blink_cnt_q;

    // Counts committed frames whose colon matches the previous commit; saturates at the timeout.
    always_ff @(posedge clk_1ms or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            blink_err   <= 1'b0;
        end else if (commit) begin
            if (colon_d != colon) begin
                blink_cnt_q <= '0;
                blink_err   <= 1'b0;
            end else begin
                if (blink_cnt_q != CNT_W'(BLINK_TIMEOUT_FRAMES)) begin
                    blink_cnt_q <= blink_cnt_q + CNT_W'(1);
                end
                if (blink_cnt_q >= CNT_W'(BLINK_TIMEOUT_FRAMES - 1)) begin
                    blink_err <= 1'b1;
                end
            end
        end
    end
`else
    assign blink_err = 1'b0;
`endif

endmodule

// File: tb/tb_display_scan_decoder.sv
// Randomized plus directed bench for display_scan_decoder against a frame-level reference model.
module tb_display_scan_decoder;

    logic       clk_1ms = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] segment_data = 7'd0;
    logic [2:0] digit_select = 3'd0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic       colon, frame_valid, locked, seq_err, seg_err, range_err, blink_err;

    display_scan_decoder dut (
        .clk_1ms      (clk_1ms),
        .reset_n      (reset_n),
        .segment_data (segment_data),
        .digit_select (digit_select),
        .hours        (hours),
        .minutes      (minutes),
        .colon        (colon),
        .frame_valid  (frame_valid),
        .locked       (locked),
        .seq_err      (seq_err),
        .seg_err      (seg_err),
        .range_err    (range_err),
        .blink_err    (blink_err)
    );

    always #5 clk_1ms = ~clk_1ms;

    logic [6:0] segt [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame under construction is the list of patterns seen so far,
    // and the only legal next index is the list length.
    int         m_hours, m_minutes, m_colon, m_fv, m_seq, m_seg, m_rng, m_locked, m_blink, m_cnt;
    int         n_in;
    logic [6:0] fr [5];

    function automatic int dec_digit(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (segt[i] == p) return i;
        return -1;
    endfunction

    task automatic eval_frame();
        int d0, d1, d3, d4, c, mm, hh;
        d0 = dec_digit(fr[0]);
        d1 = dec_digit(fr[1]);
        d3 = dec_digit(fr[3]);
        d4 = dec_digit(fr[4]);
        c  = (fr[2] == 7'h7F) ? 1 : (fr[2] == 7'h00) ? 0 : -1;
        if (d0 < 0 || d1 < 0 || d3 < 0 || d4 < 0 || c < 0) begin
            m_seg = 1;
        end else begin
            mm = d1 * 10 + d0;
            hh = d4 * 10 + d3;
            if (mm > 59 || hh > 23) begin
                m_rng = 1;
            end else begin
`ifdef COLON_BLINK_CHECK_EN
                if (c != m_colon) begin
                    m_cnt   = 0;
                    m_blink = 0;
                end else begin
                    if (m_cnt < 400) m_cnt++;
                    if (m_cnt >= 400) m_blink = 1;
                end
`endif
                m_hours   = hh;
                m_minutes = mm;
                m_colon   = c;
                m_fv      = 1;
            end
        end
    endtask

    task automatic model_step(input int sel, input logic [6:0] seg);
        m_fv = 0; m_seq = 0; m_seg = 0; m_rng = 0;
        if (sel > 4) begin
            m_seq = 1; m_locked = 0; n_in = 0;
        end else if (m_locked == 0) begin
            if (sel == 0) begin
                fr[0] = seg; n_in = 1; m_locked = 1;
            end
        end else if (sel == n_in) begin
            fr[sel] = seg;
            n_in++;
            if (n_in == 5) begin
                eval_frame();
                n_in = 0;
            end
        end else begin
            m_seq = 1;
            if (sel == 0) begin
                fr[0] = seg; n_in = 1;
            end else begin
                m_locked = 0; n_in = 0;
            end
        end
    endtask

    always @(posedge clk_1ms) begin
        if (!reset_n) begin
            m_hours = 0; m_minutes = 0; m_colon = 0; m_fv = 0; m_seq = 0; m_seg = 0;
            m_rng = 0; m_locked = 0; m_blink = 0; m_cnt = 0; n_in = 0;
        end else begin
            model_step(int'(digit_select), segment_data);
        end
    end

    always @(negedge clk_1ms) begin
        chk("hours",       int'(hours),       m_hours);
        chk("minutes",     int'(minutes),     m_minutes);
        chk("colon",       int'(colon),       m_colon);
        chk("frame_valid", int'(frame_valid), m_fv);
        chk("locked",      int'(locked),      m_locked);
        chk("seq_err",     int'(seq_err),     m_seq);
        chk("seg_err",     int'(seg_err),     m_seg);
        chk("range_err",   int'(range_err),   m_rng);
        chk("blink_err",   int'(blink_err),   m_blink);
    end

    task automatic drv(input int sel, input logic [6:0] seg);
        @(negedge clk_1ms);
        digit_select = 3'(sel);
        segment_data = seg;
    endtask

    task automatic frame(input int h, input int m, input bit c);
        drv(0, segt[m % 10]);
        drv(1, segt[m / 10]);
        drv(2, c ? 7'h7F : 7'h00);
        drv(3, segt[h % 10]);
        drv(4, segt[h / 10]);
    endtask

    task automatic settle();
        @(posedge clk_1ms);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk_1ms);
        #2 reset_n = 1'b0;
        @(negedge clk_1ms);
        #2 reset_n = 1'b1;
    endtask

    logic [6:0] pats [5];

    initial begin
        repeat (2) @(posedge clk_1ms);
        #1;
        chk("rst_hours", int'(hours), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_fv", int'(frame_valid), 0);
        @(negedge clk_1ms);
        #2 reset_n = 1'b1;

        frame(12, 34, 1'b1);
        settle();
        chk("t1_fv", int'(frame_valid), 1);
        chk("t1_hours", int'(hours), 12);
        chk("t1_minutes", int'(minutes), 34);
        chk("t1_colon", int'(colon), 1);

        drv(0, segt[9]);
        drv(1, segt[5]);
        pulse_reset();
        chk("rst_mid_hours", int'(hours), 0);
        drv(3, segt[3]);
        drv(4, segt[2]);
        settle();
        chk("t2_no_commit", int'(frame_valid), 0);
        chk("t2_unlocked", int'(locked), 0);
        frame(23, 59, 1'b0);
        settle();
        chk("t2_fv", int'(frame_valid), 1);
        chk("t2_hours", int'(hours), 23);
        chk("t2_minutes", int'(minutes), 59);

        drv(0, segt[0]);
        drv(1, segt[0]);
        drv(3, segt[0]);
        settle();
        chk("t3_seq_err", int'(seq_err), 1);
        chk("t3_locked", int'(locked), 0);
        frame(12, 34, 1'b1);
        settle();
        chk("t3_fv", int'(frame_valid), 1);

        drv(0, segt[4]);
        drv(1, 7'b0000001);
        drv(2, 7'h7F);
        drv(3, segt[2]);
        drv(4, segt[1]);
        settle();
        chk("t4_seg_err", int'(seg_err), 1);
        chk("t4_hours", int'(hours), 12);
        chk("t4_minutes", int'(minutes), 34);

        frame(25, 61, 1'b0);
        settle();
        chk("t5_range_err", int'(range_err), 1);
        chk("t5_fv", int'(frame_valid), 0);
        chk("t5_hours", int'(hours), 12);
        chk("t5_colon", int'(colon), 1);

        frame(24, 0, 1'b1);
        settle();
        chk("hr24_range_err", int'(range_err), 1);
        frame(0, 0, 1'b0);
        settle();
        chk("zero_fv", int'(frame_valid), 1);
        chk("zero_hours", int'(hours), 0);
        drv(6, segt[0]);
        settle();
        chk("idx6_seq_err", int'(seq_err), 1);

        for (int k = 0; k < 300; k++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 13) begin
                frame(int'($urandom_range(0, 29)), int'($urandom_range(0, 69)), 1'($urandom));
            end else if (r < 16) begin
                pats[0] = segt[$urandom_range(0, 9)];
                pats[1] = segt[$urandom_range(0, 5)];
                pats[2] = 7'h7F;
                pats[3] = segt[$urandom_range(0, 9)];
                pats[4] = segt[$urandom_range(0, 1)];
                pats[$urandom_range(0, 4)] = 7'($urandom);
                for (int p = 0; p < 5; p++) drv(p, pats[p]);
            end else if (r < 19) begin
                drv(int'($urandom_range(0, 7)), 7'($urandom));
            end else begin
                drv(0, segt[1]);
                pulse_reset();
            end
        end

`ifdef COLON_BLINK_CHECK_EN
        repeat (402) frame(12, 0, 1'b1);
        settle();
        chk("blink_set", int'(blink_err), 1);
        frame(12, 1, 1'b0);
        settle();
        chk("blink_clear", int'(blink_err), 0);
`endif

        repeat (3) @(negedge clk_1ms);
        #1;
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
